// File: rtl/fire_encoder_if.sv
// Handshake/bus bundle between a Fire-code encoder and its client.
//   start    : request to encode data_in (client -> encoder)
//   data_in  : K-bit message, bit K-1 shifted first (client -> encoder)
//   data_out : N-bit codeword {message, parity} (encoder -> client)
//   done     : one-cycle pulse when data_out updates (encoder -> client)
//   busy     : high while an encode is in progress (encoder -> client)
interface fire_encoder_if #(
  parameter int unsigned N = 64,
  parameter int unsigned K = 40
);
  logic         start;
  logic [K-1:0] data_in;
  logic [N-1:0] data_out;
  logic         done;
  logic         busy;

  modport master (output start, data_in, input data_out, done, busy);
  modport slave  (input start, data_in, output data_out, done, busy);
endinterface

// File: rtl/fire_encoder.sv
// Systematic serial encoder for the (64,40) Fire code, g(x) = x^24+x^19+x^15+x^9+x^4+1.
// Parity is d(x)*x^24 mod g(x), produced by a 24-bit LFSR one message bit per clock, MSB first.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fire_encoder_if slave (start, data_in in; data_out, done, busy out)
module fire_encoder #(
  parameter int unsigned     N     = 64,
  parameter int unsigned     K     = 40,
  parameter logic [N-K-1:0]  GPOLY = 24'h088211
) (
  input  logic           clk,
  input  logic           reset,
  fire_encoder_if.slave  bus
);

  localparam int unsigned P  = N - K;
  localparam int unsigned CW = $clog2(K);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [P-1:0]   rem;
  logic [K-1:0]   msg;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   data_out;
  logic           done;
  logic           busy;

  logic           bit_c;
  logic           fb_c;
  logic [P-1:0]   rem_next_c;

  // One LFSR step: current message bit folded into the top of the remainder.
  always_comb begin
    bit_c      = msg[cnt];
    fb_c       = rem[P-1] ^ bit_c;
    rem_next_c = {rem[P-2:0], 1'b0} ^ (fb_c ? GPOLY : '0);
  end

  // Control FSM with LFSR, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      msg      <= '0;
      cnt      <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            msg   <= bus.data_in;
            rem   <= '0;
            cnt   <= CW'(K - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          rem <= rem_next_c;
          cnt <= cnt - CW'(1);
          // Last message bit: publish the codeword using this edge's remainder.
          if (cnt == '0) begin
            data_out <= {msg, rem_next_c};
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out;
  assign bus.done     = done;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_fire_encoder.sv
// Self-checking bench for fire_encoder: polynomial-division reference model,
// directed vectors, random linearity/divisibility, handshake corner cases,
// mid-encode reset and burst-error loopback through a search-based corrector.
module tb_fire_encoder;

  localparam int unsigned N = 64;
  localparam int unsigned K = 40;
  localparam logic [24:0] G25 = 25'h1088211;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  fire_encoder_if #(.N(N), .K(K)) bus ();

  fire_encoder #(.N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Remainder of a 64-coefficient polynomial divided by g(x), by long division.
  function automatic logic [23:0] poly_mod(input logic [63:0] c);
    logic [63:0] r;
    r = c;
    for (int i = 63; i >= 24; i--)
      if (r[i]) r = r ^ (64'(G25) << (i - 24));
    return r[23:0];
  endfunction

  function automatic logic [63:0] model_enc(input logic [39:0] d);
    return {d, poly_mod({d, 24'h0})};
  endfunction

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Find the burst (length <= 8) whose syndrome matches and remove it.
  function automatic logic [63:0] correct_burst(input logic [63:0] rx);
    logic [23:0] s;
    logic [63:0] e;
    s = poly_mod(rx);
    if (s == 24'h0) return rx;
    for (int pos = 0; pos < 64; pos++)
      for (int p = 1; p < 256; p += 2) begin
        e = 64'(p) << pos;
        if ((e >> pos) == 64'(p) && poly_mod(e) == s) return rx ^ e;
      end
    return rx;
  endfunction

  // Encode d: returns the codeword, busy cycles seen, done-pulse sanity and whether done arrived.
  task automatic run_encode(input logic [39:0] d, output logic [63:0] res,
                            output int busy_cnt, output bit got_done,
                            output bit pulse_ok, output int done_cyc);
    busy_cnt = 0;
    got_done = 0;
    pulse_ok = 0;
    done_cyc = 0;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        got_done = 1;
        done_cyc = cyc;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    res = bus.data_out;
    if (got_done) begin
      @(posedge clk); #1;
      pulse_ok = !bus.done && !bus.busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++;
    if (bus.data_out !== 64'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out=%h done=%b busy=%b, need 0/0/0", bus.data_out, bus.done, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    logic [39:0] din [3];
    logic [63:0] exp [3];
    logic [63:0] res;
    int bc, dc;
    bit gd, po;
    din[0] = 40'h0;          exp[0] = 64'h0000000000000000;
    din[1] = 40'h0000000001; exp[1] = 64'h0000000001088211;
    din[2] = 40'h0000000002; exp[2] = 64'h0000000002110422;
    for (int i = 0; i < 3; i++) begin
      run_encode(din[i], res, bc, gd, po, dc);
      total++;
      if (!gd) begin bad++; $display("FAIL vec%0d_done: no done within bound", i); end
      total++;
      if (res !== exp[i]) begin bad++; $display("FAIL vec%0d_data: got %h need %h", i, res, exp[i]); end
      total++;
      if (bc !== 40) begin bad++; $display("FAIL vec%0d_busy: busy cycles %0d need 40", i, bc); end
      total++;
      if (po !== 1'b1) begin bad++; $display("FAIL vec%0d_pulse: done/busy not low after pulse (got %b need 1)", i, po); end
    end
  endtask

  task automatic test_random();
    logic [39:0] a, b;
    logic [63:0] ra, rb, rab;
    int bc, dc;
    bit g1, g2, g3, po;
    for (int i = 0; i < 200; i++) begin
      a = rand40();
      b = rand40();
      run_encode(a, ra, bc, g1, po, dc);
      run_encode(b, rb, bc, g2, po, dc);
      run_encode(a ^ b, rab, bc, g3, po, dc);
      total++;
      if (!(g1 && g2 && g3)) begin bad++; $display("FAIL rand%0d_done: done missing", i); end
      total++;
      if (ra !== model_enc(a)) begin bad++; $display("FAIL rand%0d_model: got %h need %h", i, ra, model_enc(a)); end
      total++;
      if (rab !== (ra ^ rb)) begin bad++; $display("FAIL rand%0d_linear: got %h need %h", i, rab, ra ^ rb); end
      total++;
      if (poly_mod(rab) !== 24'h0) begin bad++; $display("FAIL rand%0d_div: remainder %h need 0", i, poly_mod(rab)); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [39:0] d1, d2;
    int n;
    bit gd;
    d1 = rand40();
    d2 = ~d1;
    gd = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = d1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.data_in = d2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    gd = bus.done;
    total++;
    if (!gd) begin bad++; $display("FAIL ignore_done: no done within bound"); end
    total++;
    if (bus.data_out !== model_enc(d1)) begin
      bad++; $display("FAIL ignore_data: got %h need %h", bus.data_out, model_enc(d1));
    end
    // No second encode should have been queued.
    n = 0;
    repeat (50) begin @(posedge clk); #1; if (bus.done || bus.busy) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL ignore_noqueue: %0d active cycles need 0", n); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] d1, d2;
    logic [63:0] r1;
    int c1, c2, n;
    d1 = rand40();
    d2 = rand40();
    c1 = 0; c2 = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = d1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    c1 = cyc;
    r1 = bus.data_out;
    bus.start = 1'b1; bus.data_in = d2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
    c2 = cyc;
    total++;
    if (r1 !== model_enc(d1)) begin bad++; $display("FAIL b2b_first: got %h need %h", r1, model_enc(d1)); end
    total++;
    if (bus.data_out !== model_enc(d2)) begin bad++; $display("FAIL b2b_second: got %h need %h", bus.data_out, model_enc(d2)); end
    total++;
    if (c2 - c1 !== 41) begin bad++; $display("FAIL b2b_spacing: %0d cycles need 41", c2 - c1); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int bc, dc, n;
    bit gd, po;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.data_in = rand40();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.data_out !== 64'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: out=%h done=%b busy=%b, need 0/0/0", bus.data_out, bus.done, bus.busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    repeat (60) begin @(posedge clk); #1; if (bus.done || bus.busy) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL midreset_idle: %0d active cycles need 0", n); end
    run_encode(40'h0000000001, res, bc, gd, po, dc);
    total++;
    if (!gd || res !== 64'h0000000001088211) begin
      bad++; $display("FAIL midreset_fresh: got %h need 0000000001088211", res);
    end
  endtask

  task automatic test_loopback();
    logic [39:0] d;
    logic [63:0] res, e, fixed;
    int bc, dc, len, pos, p;
    bit gd, po;
    for (int i = 0; i < 6; i++) begin
      d = rand40();
      run_encode(d, res, bc, gd, po, dc);
      total++;
      if (!gd || poly_mod(res) !== 24'h0) begin
        bad++; $display("FAIL loop%0d_syndrome: %h need 0", i, poly_mod(res));
      end
      len = $urandom_range(1, 8);
      p = int'($urandom_range(0, 255)) | 1 | (1 << (len - 1));
      p = p & ((1 << len) - 1);
      pos = $urandom_range(0, 64 - len);
      e = 64'(p) << pos;
      fixed = correct_burst(res ^ e);
      total++;
      if (fixed[63:24] !== d) begin
        bad++; $display("FAIL loop%0d_correct: got %h need %h", i, fixed[63:24], d);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.start = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
